// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: opcode codes and sequencer state encoding for dsp_seq_core
package dsp_seq_pkg;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_EX = 2'd2} state_t;
endpackage

// File: rtl/dsp_seq_ram.sv
// dsp_seq_ram: 2**ADDR_W x DATA_W scratch RAM, sync write, sync read, no reset
// ports: clk, we, addr, din -> dout (registered read of addr)
module dsp_seq_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/dsp_seq_core.sv
// dsp_seq_core: accumulator core, IDLE->RD->EX sequencer, one instruction per 3 cycles
// ports: clk, rst (sync, high); instr_valid/instr_ready handshake with opcode, mem_addr, imm_val;
//        acc_out, carry_out, zero_out registered results; done one-cycle retire pulse
// DSP_SEQ_SAT_EN: ADD saturates to all-ones on carry, SUB saturates to zero on borrow
module dsp_seq_core
  import dsp_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] imm_val,
  output logic [DATA_W-1:0] acc_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              done
);
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] imm_q, ram_q, res, add_r, sub_r;
  logic [DATA_W:0] sum, diff;
  logic res_c, ram_we, accept;
  dsp_seq_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(ram_we), .addr(addr_q), .din(acc_out), .dout(ram_q)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_IDLE ? (accept ? S_RD : S_IDLE) : state == S_RD ? S_EX : S_IDLE;
  end
  // rst gates the write so a reset during EX abandons a pending ST
  always_comb begin
    instr_ready = state == S_IDLE && !rst;
    accept = instr_valid && instr_ready;
    ram_we = state == S_EX && op_q == OP_ST && !rst;
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= opcode;
      addr_q <= mem_addr;
      imm_q <= imm_val;
    end
  end
  assign sum = {1'b0, acc_out} + {1'b0, ram_q};
  assign diff = {1'b0, acc_out} - {1'b0, ram_q};
`ifdef DSP_SEQ_SAT_EN
  assign add_r = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  assign sub_r = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
  assign add_r = sum[DATA_W-1:0];
  assign sub_r = diff[DATA_W-1:0];
`endif
  always_comb begin
    res = acc_out;
    res_c = carry_out;
    case (op_q)
      OP_LDI: begin res = imm_q; res_c = 1'b0; end
      OP_LD:  begin res = ram_q; res_c = 1'b0; end
      OP_ADD: begin res = add_r; res_c = sum[DATA_W]; end
      OP_SUB: begin res = sub_r; res_c = diff[DATA_W]; end
      OP_AND: begin res = acc_out & ram_q; res_c = 1'b0; end
      OP_XOR: begin res = acc_out ^ ram_q; res_c = 1'b0; end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      carry_out <= 1'b0;
      zero_out <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= state == S_EX;
      if (state == S_EX) begin
        acc_out <= res;
        carry_out <= res_c;
        zero_out <= ~|res;
      end
    end
  end
endmodule

// File: tb/tb_dsp_seq_core.sv
// tb_dsp_seq_core: randomized scoreboard bench for dsp_seq_core against an arithmetic model
module tb_dsp_seq_core;
  localparam int DW = 4, AW = 4, MOD = 16;
`ifdef DSP_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
  logic [2:0] opcode = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] imm_val = '0;
  logic instr_ready, carry_out, zero_out, done;
  logic [DW-1:0] acc_out;
  dsp_seq_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .mem_addr(mem_addr), .imm_val(imm_val), .acc_out(acc_out),
    .carry_out(carry_out), .zero_out(zero_out), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {int acc; int c; int z; int cyc;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0, checks = 0, failures = 0, naccept = 0;
  int m_acc = 0, m_c = 0;
  int m_mem[MOD];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void model(int op, int a, int imm);
    int m = m_mem[a];
    case (op)
      1: begin m_acc = imm; m_c = 0; end
      2: begin m_acc = m; m_c = 0; end
      3: m_mem[a] = m_acc;
      4: begin
        m_c = (m_acc + m >= MOD) ? 1 : 0;
        m_acc = m_c == 0 ? m_acc + m : (SAT ? MOD - 1 : m_acc + m - MOD);
      end
      5: begin
        m_c = (m_acc < m) ? 1 : 0;
        m_acc = m_c == 0 ? m_acc - m : (SAT ? 0 : m_acc - m + MOD);
      end
      6: begin m_acc = m_acc & m; m_c = 0; end
      7: begin m_acc = m_acc ^ m; m_c = 0; end
      default: ;
    endcase
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("acc_out", int'(acc_out), mon_e.acc);
        chk("carry_out", int'(carry_out), mon_e.c);
        chk("zero_out", int'(zero_out), mon_e.z);
        chk("done_latency", cyc, mon_e.cyc);
      end
    end
  end
  task automatic step(bit v, int op, int a, int imm);
    @(negedge clk);
    instr_valid = v;
    opcode = 3'(op);
    mem_addr = AW'(a);
    imm_val = DW'(imm);
    if (v && instr_ready && !rst) begin
      model(op, a, imm);
      q.push_back('{m_acc, m_c, (m_acc == 0) ? 1 : 0, cyc + 3});
      naccept++;
    end
  endtask
  task automatic issue(int op, int a, int imm);
    int n0 = naccept;
    for (int i = 0; i < 10 && naccept == n0; i++) step(1'b1, op, a, imm);
    if (naccept == n0) chk("accept_timeout", 0, 1);
  endtask
  task automatic idle();
    step(1'b0, $urandom_range(7), $urandom_range(MOD - 1), $urandom_range(MOD - 1));
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    idle();
  endtask
  initial begin
    int n0;
    repeat (2) @(negedge clk);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_carry", int'(carry_out), 0);
    chk("rst_zero", int'(zero_out), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(instr_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(instr_ready), 1);
    for (int a = 0; a < MOD; a++) begin
      issue(1, 0, $urandom_range(MOD - 1));
      issue(3, a, 0);
    end
    issue(1, 0, 9); issue(3, 3, 0); issue(1, 0, 0); issue(2, 3, 0);
    drain();
    chk("t2_acc", int'(acc_out), 9);
    chk("t2_zero", int'(zero_out), 0);
    issue(1, 0, 12); issue(3, 1, 0); issue(1, 0, 7); issue(4, 1, 0);
    drain();
    chk("t3_acc", int'(acc_out), SAT ? 15 : 3);
    chk("t3_carry", int'(carry_out), 1);
    issue(1, 0, 5); issue(3, 2, 0); issue(1, 0, 2); issue(5, 2, 0);
    drain();
    chk("t4_acc", int'(acc_out), SAT ? 0 : 13);
    chk("t4_carry", int'(carry_out), 1);
    chk("t4_zero", int'(zero_out), SAT ? 1 : 0);
    issue(1, 0, 5); issue(5, 2, 0);
    drain();
    chk("t4b_acc", int'(acc_out), 0);
    chk("t4b_zero", int'(zero_out), 1);
    chk("t4b_carry", int'(carry_out), 0);
    n0 = naccept;
    for (int i = 0; i < 30; i++) step(1'b1, $urandom_range(7), $urandom_range(MOD - 1), $urandom_range(MOD - 1));
    chk("t5_accepts", naccept - n0, 10);
    drain();
    issue(1, 0, 1); issue(3, 2, 0); issue(1, 0, 6); issue(3, 2, 0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    q.delete();
    m_acc = 0;
    m_c = 0;
    m_mem[2] = 1;
    @(negedge clk);
    chk("t6_acc", int'(acc_out), 0);
    chk("t6_zero", int'(zero_out), 1);
    chk("t6_ready", int'(instr_ready), 0);
    rst = 1'b0;
    issue(2, 2, 0);
    drain();
    chk("t6_mem", int'(acc_out), 1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(1)), $urandom_range(7), $urandom_range(MOD - 1), $urandom_range(MOD - 1));
    drain();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
